alu_seq: RTL and testbench

//  Parametrised sequential successor of the 4-bit lab ALU. Operand width is WIDTH.

---
 rtl/alu_seq.sv | 184 ++++++++++++++++++
 tb/tb_alu_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative shift-add MUL and
// restoring DIV, with valid/ready handshakes on both the operand and result sides.
module alu_seq #(
  parameter int WIDTH     = 4,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [4:0]           select,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 zero,
  output logic                 carry,
  output logic                 neg,
  output logic                 ovf,
  output logic                 err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [4:0] {
    OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3,
    OP_OR  = 5'd4,  OP_XOR = 5'd5,  OP_NOT = 5'd6,  OP_SHL = 5'd7,
    OP_SHR = 5'd8,  OP_SAR = 5'd9,  OP_ROL = 5'd10, OP_ROR = 5'd11,
    OP_MUL = 5'd12, OP_DIV = 5'd13, OP_CMP = 5'd14, OP_INC = 5'd15
  } op_e;

  state_t                r_state, w_state_nxt;
  logic [2*WIDTH-1:0]    r_p;        // MUL: {acc, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]      r_opnd;     // multiplicand or divisor
  logic                  r_is_div;
  logic [CW-1:0]         r_cnt;

  logic [SHW-1:0]        w_sh;
  logic [SHW:0]          w_shc;
  logic [WIDTH:0]        w_sum, w_diff, w_inc;
  logic [WIDTH-1:0]      w_lo;
  logic [2*WIDTH-1:0]    w_res;
  logic                  w_c, w_v, w_err, w_start_md;
  logic                  w_last;
  logic [WIDTH:0]        w_msum, w_rsh, w_trial;
  logic [2*WIDTH-1:0]    w_p_nxt;

  assign w_sh   = B[SHW-1:0];
  assign w_shc  = (SHW+1)'(WIDTH) - {1'b0, w_sh};
  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_inc  = {1'b0, A} + (WIDTH+1)'(1);
  assign w_last = (r_cnt == CW'(WIDTH-1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_lo       = '0;
    w_c        = 1'b0;
    w_v        = 1'b0;
    w_err      = 1'b0;
    w_start_md = 1'b0;
    case (select)
      OP_NOP: w_lo = '0;
      OP_ADD: begin
        w_lo = w_sum[WIDTH-1:0];
        w_c  = w_sum[WIDTH];
        w_v  = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_lo = w_diff[WIDTH-1:0];
        w_c  = w_diff[WIDTH];
        w_v  = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: w_lo = A & B;
      OP_OR:  w_lo = A | B;
      OP_XOR: w_lo = A ^ B;
      OP_NOT: w_lo = ~A;
      OP_SHL: w_lo = A << w_sh;
      OP_SHR: w_lo = A >> w_sh;
      OP_SAR: w_lo = $unsigned($signed(A) >>> w_sh);
      OP_ROL: w_lo = (A << w_sh) | (A >> w_shc);
      OP_ROR: w_lo = (A >> w_sh) | (A << w_shc);
      OP_MUL, OP_DIV: begin
        if (MULDIV_EN) w_start_md = 1'b1;
        else           w_err      = 1'b1;
      end
      OP_CMP: w_lo = '0;
      OP_INC: begin
        w_lo = w_inc[WIDTH-1:0];
        w_c  = w_inc[WIDTH];
        w_v  = ~A[WIDTH-1] & w_inc[WIDTH-1];
      end
      default: w_err = 1'b1;
    endcase
    w_res = {{WIDTH{1'b0}}, w_lo};
    if (select == OP_CMP)
      w_res = {{(2*WIDTH-3){1'b0}}, (A > B), (A == B), (A < B)};
  end

  // One MUL or DIV iteration on the shared product/remainder register.
  always_comb begin
    w_msum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
    w_rsh   = r_p[2*WIDTH-1:WIDTH-1];
    w_trial = w_rsh - {1'b0, r_opnd};
    if (!r_is_div)
      w_p_nxt = {w_msum, r_p[WIDTH-1:1]};
    else if (!w_trial[WIDTH])
      w_p_nxt = {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
    else
      w_p_nxt = {w_rsh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_start_md ? S_BUSY : S_DONE;
      end
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    // NOTE: the synchronous reset clears every register, including the iteration datapath.
    if (!res) begin
      r_state  <= S_IDLE;
      r_p      <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      out      <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (in_valid) begin
          if (w_start_md) begin
            r_p      <= {{WIDTH{1'b0}}, (select[0] ? A : B)};
            r_opnd   <= select[0] ? B : A;
            r_is_div <= select[0];
            r_cnt    <= '0;
          end else begin
            out   <= w_res;
            zero  <= (w_res == '0);
            carry <= w_c;
            neg   <= w_res[WIDTH-1];
            ovf   <= w_v;
            err   <= w_err;
          end
        end
        S_BUSY: begin
          r_p   <= w_p_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            out   <= w_p_nxt;
            zero  <= (w_p_nxt == '0);
            carry <= 1'b0;
            ovf   <= 1'b0;
            neg   <= r_is_div ? w_p_nxt[WIDTH-1] : w_p_nxt[2*WIDTH-1];
            err   <= r_is_div && (r_opnd == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): directed vector table, handshake and
// reset corner sequences, and randomized operations against an arithmetic model.
module tb_alu_seq;

  localparam int W = 4;
  localparam int M = 1 << W;
  localparam int H = 1 << (W-1);

  logic           clk, res, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   a_in, b_in;
  logic [4:0]     sel;
  logic [2*W-1:0] dut_out;
  logic           zero, carry, neg, ovf, err;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .select(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out(dut_out), .zero(zero), .carry(carry), .neg(neg), .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0]   a, b;
    logic [4:0]     sel;
    logic [2*W-1:0] eo;
    logic [4:0]     ef;   // {zero, carry, neg, ovf, err}
    int             el;
  } vec_t;

  vec_t vecs [29];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Arithmetic reference: results from integer math on the operand values.
  function automatic void model(input int a, input int b, input int s,
                                output logic [2*W-1:0] o, output logic [4:0] f, output int lat);
    int r, sh, sa, sb;
    bit c, v, e, n;
    r = 0; c = 0; v = 0; e = 0; lat = 1;
    sh = b % W;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    case (s)
      0:  r = 0;
      1:  begin r = a + b; c = (r >= M); v = (sa + sb > H - 1) || (sa + sb < -H); r = r % M; end
      2:  begin r = (a - b + M) % M; c = (a < b); v = (sa - sb > H - 1) || (sa - sb < -H); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = (M - 1) - a;
      7:  r = (a << sh) % M;
      8:  r = a >> sh;
      9:  r = (sa >>> sh) & (M - 1);
      10: r = ((a << sh) | (a >> (W - sh))) % M;
      11: r = ((a >> sh) | (a << (W - sh))) % M;
      12: begin r = a * b; lat = W + 1; end
      13: begin
        lat = W + 1;
        if (b == 0) begin r = a * M + (M - 1); e = 1; end
        else r = (a % b) * M + a / b;
      end
      14: r = (a > b) ? 4 : (a == b) ? 2 : 1;
      15: begin r = a + 1; c = (r >= M); v = (sa + 1 > H - 1); r = r % M; end
      default: begin r = 0; e = 1; end
    endcase
    o = (2*W)'(r);
    n = (s == 12) ? o[2*W-1] : o[W-1];
    f = {(r == 0), c, n, v, e};
  endfunction

  // Called at a negedge with the DUT idle; returns result, flags and latency
  // (number of falling edges from the transfer edge until out_valid is seen).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] s,
                       input int hold, output logic [2*W-1:0] o, output logic [4:0] f,
                       output int lat);
    int guard;
    a_in = a; b_in = b; sel = s; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    o = dut_out;
    f = {zero, carry, neg, ovf, err};
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] o, eo;
    logic [4:0]     f, ef;
    int             lat, el, cnt;

    vecs[0]  = '{4'd4,  4'd9,  5'd1,  8'h0D, 5'b00100, 1};
    vecs[1]  = '{4'd4,  4'd9,  5'd2,  8'h0B, 5'b01110, 1};
    vecs[2]  = '{4'd7,  4'd1,  5'd1,  8'h08, 5'b00110, 1};
    vecs[3]  = '{4'd13, 4'd15, 5'd12, 8'hC3, 5'b00100, 5};
    vecs[4]  = '{4'd9,  4'd6,  5'd13, 8'h31, 5'b00000, 5};
    vecs[5]  = '{4'd9,  4'd0,  5'd13, 8'h9F, 5'b00101, 5};
    vecs[6]  = '{4'd9,  4'd6,  5'd10, 8'h06, 5'b00000, 1};
    vecs[7]  = '{4'd3,  4'd5,  5'd20, 8'h00, 5'b10001, 1};
    vecs[8]  = '{4'd5,  4'd0,  5'd6,  8'h0A, 5'b00100, 1};
    vecs[9]  = '{4'd8,  4'd1,  5'd9,  8'h0C, 5'b00100, 1};
    vecs[10] = '{4'd3,  4'd6,  5'd7,  8'h0C, 5'b00100, 1};
    vecs[11] = '{4'd11, 4'd4,  5'd8,  8'h0B, 5'b00100, 1};
    vecs[12] = '{4'd3,  4'd9,  5'd14, 8'h01, 5'b00000, 1};
    vecs[13] = '{4'd15, 4'd0,  5'd15, 8'h00, 5'b11000, 1};
    vecs[14] = '{4'd5,  4'd5,  5'd2,  8'h00, 5'b10000, 1};
    vecs[15] = '{4'd3,  4'd3,  5'd0,  8'h00, 5'b10000, 1};
    vecs[16] = '{4'd15, 4'd15, 5'd12, 8'hE1, 5'b00100, 5};
    vecs[17] = '{4'd0,  4'd7,  5'd12, 8'h00, 5'b10000, 5};
    vecs[18] = '{4'd1,  4'd1,  5'd11, 8'h08, 5'b00100, 1};
    vecs[19] = '{4'd9,  4'd3,  5'd14, 8'h04, 5'b00000, 1};
    vecs[20] = '{4'd12, 4'd10, 5'd3,  8'h08, 5'b00100, 1};
    vecs[21] = '{4'd12, 4'd10, 5'd5,  8'h06, 5'b00000, 1};
    vecs[22] = '{4'd0,  4'd0,  5'd4,  8'h00, 5'b10000, 1};
    vecs[23] = '{4'd15, 4'd1,  5'd13, 8'h0F, 5'b00100, 5};
    vecs[24] = '{4'd8,  4'd1,  5'd2,  8'h07, 5'b00010, 1};
    vecs[25] = '{4'd9,  4'd4,  5'd10, 8'h09, 5'b00100, 1};
    vecs[26] = '{4'd6,  4'd3,  5'd9,  8'h00, 5'b10000, 1};
    vecs[27] = '{4'd1,  4'd2,  5'd31, 8'h00, 5'b10001, 1};
    vecs[28] = '{4'd15, 4'd3,  5'd7,  8'h08, 5'b00100, 1};

    // Reset held for two edges while in_valid is asserted.
    res = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a_in = 4'd7; b_in = 4'd1; sel = 5'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out", 64'(dut_out), 64'h0);
    check("reset_flags", 64'({zero, carry, neg, ovf, err}), 64'h0);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    res = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'h1);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sel, 0, o, f, lat);
      check($sformatf("vec%0d_out", i),   64'(o),   64'(vecs[i].eo));
      check($sformatf("vec%0d_flags", i), 64'(f),   64'(vecs[i].ef));
      check($sformatf("vec%0d_lat", i),   64'(lat), 64'(vecs[i].el));
    end

    // Backpressure: result held and new operands ignored while out_ready is low.
    a_in = 4'd7; b_in = 4'd1; sel = 5'd1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      a_in = 4'(k + 2); b_in = 4'd3; sel = 5'd2;
      check($sformatf("hold%0d_out", k), 64'(dut_out), 64'h08);
      check($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'h0);
      check($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'h1);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a MUL abandons it.
    a_in = 4'd13; b_in = 4'd15; sel = 5'd12; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    res = 1'b1; out_ready = 1'b0;
    check("midmul_rst_out_valid", 64'(out_valid), 64'h0);
    check("midmul_rst_out", 64'(dut_out), 64'h0);
    check("midmul_rst_in_ready", 64'(in_ready), 64'h1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midmul_no_stale_result", 64'(cnt), 64'h0);

    // Throughput with both handshakes held high: one transfer every two cycles.
    a_in = 4'd1; b_in = 4'd2; sel = 5'd1; in_valid = 1'b1; out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (in_ready) cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("throughput_10cyc", 64'(cnt), 64'd5);

    // Randomized operations against the arithmetic model.
    for (int k = 0; k < 200; k++) begin
      logic [W-1:0] ra, rb;
      logic [4:0]   rs;
      ra = W'($urandom_range(0, M - 1));
      rb = W'($urandom_range(0, M - 1));
      rs = ($urandom_range(0, 3) == 0) ? 5'(12 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
      model(int'(ra), int'(rb), int'(rs), eo, ef, el);
      do_op(ra, rb, rs, $urandom_range(0, 2), o, f, lat);
      check($sformatf("rnd%0d_op%0d_a%0d_b%0d_out", k, rs, ra, rb), 64'(o), 64'(eo));
      check($sformatf("rnd%0d_op%0d_a%0d_b%0d_flags", k, rs, ra, rb), 64'(f), 64'(ef));
      check($sformatf("rnd%0d_op%0d_lat", k, rs), 64'(lat), 64'(el));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
